// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- Fetch-stage sequencer
//
// Owns the program counter and issues single-outstanding word requests to
// instruction memory. Returned words are buffered in a small FIFO that decode
// drains with a valid/ready handshake. A taken branch redirects the PC, flushes
// the FIFO and squashes any response still in flight.
//
// A queue slot is reserved when a request is issued (occupancy + in-flight <
// QDEPTH), so a returning word can always be pushed.
//
// Optional feature: define FETCH_STATS_EN to add the saturating statistics
// outputs stat_fetched / stat_squashed. When it is undefined those ports and
// counters do not exist and all other behaviour is identical.
//
// Parameters
//   XLEN      address / instruction width
//   RESET_PC  first fetch address after reset
//   QDEPTH    instruction queue entries (power of two, >= 2)
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active-low
//   branch        in   taken-branch redirect strobe (1 cycle)
//   branch_res    in   redirect target (low two bits ignored)
//   imem_req      out  request to instruction memory (registered)
//   imem_addr     out  request address, word aligned (registered)
//   imem_gnt      in   memory accepts the request this cycle
//   imem_rvalid   in   response word valid
//   imem_rdata    in   response word
//   inst_valid    out  queue head valid to decode
//   inst          out  queue head instruction
//   inst_pc       out  PC of queue head
//   inst_ready    in   decode consumes head when inst_valid & inst_ready
//   stat_fetched  out  words pushed into the queue       (FETCH_STATS_EN only)
//   stat_squashed out  words flushed + responses dropped (FETCH_STATS_EN only)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_res,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_squashed
`endif
);

  localparam int            AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SQUASH} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] q_data [QDEPTH];
  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            slot_free;
  logic [XLEN-1:0] target;

  // Branch has priority: it blocks both the push of a returning word and the
  // pop by decode in the same cycle.
  always_comb begin
    push       = (state_reg == WAIT) && imem_rvalid && !branch;
    pop        = (count_reg != '0) && inst_ready && !branch;
    count_next = count_reg + CW'(push) - CW'(pop);
    slot_free  = count_next < DEPTH;
  end

  assign target     = branch_res & ~XLEN'(3);
  assign inst_valid = (count_reg != '0);
  assign inst       = q_data[rd_ptr_reg];
  assign inst_pc    = q_pc[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (branch) begin
      pc_reg     <= target;
      imem_req   <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      case (state_reg)
        // A granted request will still return a word that must be dropped.
        REQ:     state_reg <= imem_gnt ? SQUASH : IDLE;
        WAIT:    state_reg <= imem_rvalid ? IDLE : SQUASH;
        // If the stale word arrives together with a new branch it is consumed
        // here, so there is nothing left to wait for.
        SQUASH:  state_reg <= imem_rvalid ? IDLE : SQUASH;
        default: state_reg <= IDLE;
      endcase
    end else begin
      if (push) begin
        // imem_addr still holds the address of the outstanding request.
        q_data[wr_ptr_reg] <= imem_rdata;
        q_pc[wr_ptr_reg]   <= imem_addr;
        wr_ptr_reg         <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;

      case (state_reg)
        IDLE: begin
          if (slot_free) begin
            state_reg <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_reg;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            pc_reg    <= pc_reg + XLEN'(4);
            imem_req  <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              state_reg <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_reg;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        SQUASH: begin
          // The queue was flushed on entry, so a slot is always free here.
          if (imem_rvalid) begin
            state_reg <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  localparam int SW = CW + 1;

  logic          discard;
  logic [SW-1:0] squash_inc;

  // A response is dropped when it lands in SQUASH, or lands in WAIT together
  // with a branch. Flushed queue words are counted at the branch.
  assign discard    = imem_rvalid &&
                      ((state_reg == SQUASH) || ((state_reg == WAIT) && branch));
  assign squash_inc = (branch ? {1'b0, count_reg} : '0) + SW'(discard);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched  <= '0;
      stat_squashed <= '0;
    end else begin
      stat_fetched  <= sat_add(stat_fetched, 32'(push));
      stat_squashed <= sat_add(stat_squashed, 32'(squash_inc));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl
//
// A cycle-stepped memory model answers granted requests after a programmable
// latency. Every returned word that should survive is pushed to a scoreboard
// queue; every decode handshake pops it and compares the DUT's queue head.
// Branches clear the scoreboard and mark an in-flight response as squashed.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] branch_res;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_squashed;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .QDEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .branch_res  (branch_res),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_squashed (stat_squashed)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] grant_log[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] model_pc;
  logic [31:0] resp_pc;
  bit          outstanding;
  bit          squashing;
  int          resp_cnt;
  int          rv_lat;
  int          n_push;
  int          cyc;
  bit          gnt_en;
  bit          rdy;

  int          t1_cyc[$];
  logic [31:0] t1_pc[$];
  logic [31:0] addr_hold;
  int          n_grants;
`ifdef FETCH_STATS_EN
  logic [31:0] sq_before;
`endif

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, clock, update model.
  task automatic step(input bit br = 1'b0, input logic [31:0] tgt = 32'h0);
    bit     rv;
    bit     grant;
    bit     pop_ev;
    entry_t e;
    rv          = outstanding && (resp_cnt == 1);
    imem_gnt    = gnt_en;
    imem_rvalid = rv;
    imem_rdata  = rv ? data_of(resp_pc) : $urandom();
    inst_ready  = rdy;
    branch      = br;
    branch_res  = tgt;

    grant  = (imem_req === 1'b1) && gnt_en;
    pop_ev = (sb.size() != 0) && rdy && !br;
    if (outstanding) chk("req_while_outstanding", 32'(imem_req), 32'h0);
    if (imem_req === 1'b1) chk("imem_addr", imem_addr, model_pc);
    if (grant) grant_log.push_back(imem_addr);
    if (pop_ev) begin
      e = sb.pop_front();
      chk("head_pc", inst_pc, e.pc);
      chk("head_inst", inst, e.data);
      t1_cyc.push_back(cyc);
      t1_pc.push_back(inst_pc);
    end

    @(posedge clk);
    #1;
    cyc++;

    if (rv) begin
      outstanding = 1'b0;
      if (!br && !squashing) begin
        e.pc   = resp_pc;
        e.data = data_of(resp_pc);
        sb.push_back(e);
        n_push++;
      end
      squashing = 1'b0;
    end else if (outstanding) begin
      resp_cnt--;
    end
    if (grant) begin
      resp_pc     = model_pc;
      model_pc    = model_pc + 32'd4;
      outstanding = 1'b1;
      resp_cnt    = rv_lat;
    end
    if (br) begin
      sb.delete();
      model_pc  = tgt & ~32'h3;
      squashing = outstanding;
    end
    chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    branch      = 1'b0;
    branch_res  = 32'h0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'h0);
    chk("rst_stat_squashed", stat_squashed, 32'h0);
`endif
    sb.delete();
    grant_log.delete();
    t1_cyc.delete();
    t1_pc.delete();
    model_pc    = 32'h0;
    outstanding = 1'b0;
    squashing   = 1'b0;
    resp_cnt    = 0;
    n_push      = 0;
    cyc         = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: streaming fetch after reset release
    gnt_en = 1'b1; rdy = 1'b1; rv_lat = 1;
    do_reset();
    step();
    chk("t1_first_req", 32'(imem_req), 32'h1);
    for (int i = 0; i < 40 && t1_pc.size() < 4; i++) step();
    chk("t1_pop_count", 32'(t1_pc.size()), 32'd4);
    for (int i = 0; i < t1_pc.size() && i < 4; i++) chk("t1_pc_order", t1_pc[i], 32'(i * 4));
    for (int i = 1; i < t1_cyc.size() && i < 4; i++)
      chk("t1_issue_gap", 32'(t1_cyc[i] - t1_cyc[i-1]), 32'd2);

    // 2: decode stalled -> queue fills to QDEPTH, then drains and fetch resumes
    rdy = 1'b0;
    do_reset();
    repeat (20) step();
    chk("t2_grants", 32'(grant_log.size()), 32'd4);
    chk("t2_req_stalled", 32'(imem_req), 32'h0);
    chk("t2_full_valid", 32'(inst_valid), 32'h1);
    rdy = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 20 && grant_log.size() < 5; i++) step();
    chk("t2_resume_addr", (grant_log.size() >= 5) ? grant_log[4] : 32'hFFFF_FFFF, 32'h10);

    // 3: grant withheld -> request and address held stable
    gnt_en = 1'b0;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step();
    chk("t3_req_up", 32'(imem_req), 32'h1);
    addr_hold = imem_addr;
    repeat (5) begin
      step();
      chk("t3_req_held", 32'(imem_req), 32'h1);
      chk("t3_addr_held", imem_addr, addr_hold);
    end
    gnt_en   = 1'b1;
    n_grants = grant_log.size();
    step();
    chk("t3_granted", 32'(grant_log.size()), 32'(n_grants + 1));
    // branch while requesting without grant: request is dropped
    gnt_en = 1'b0;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step();
    step(1'b1, 32'h502);
    chk("t3_req_dropped", 32'(imem_req), 32'h0);
    gnt_en   = 1'b1;
    n_grants = grant_log.size();
    for (int i = 0; i < 20 && grant_log.size() == n_grants; i++) step();
    chk("t3_redirect_addr", (grant_log.size() > n_grants) ? grant_log[n_grants] : 32'hFFFF_FFFF,
        32'h500);

    // 4: branch while waiting for a response -> word dropped, fetch at target
    rdy = 1'b0; rv_lat = 3;
    do_reset();
    for (int i = 0; i < 60 && !(sb.size() == 2 && outstanding && resp_cnt >= 2); i++) step();
    chk("t4_setup", 32'(inst_valid), 32'h1);
`ifdef FETCH_STATS_EN
    sq_before = stat_squashed;
`endif
    step(1'b1, 32'h100);
    chk("t4_flushed", 32'(inst_valid), 32'h0);
    rdy = 1'b1;
    for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) step();
    chk("t4_target_pc", inst_pc, 32'h100);
`ifdef FETCH_STATS_EN
    chk("t4_stat_squashed", stat_squashed - sq_before, 32'd3);
    chk("t4_stat_fetched", stat_fetched, 32'(n_push));
`endif

    // 5: branch coincident with rvalid and a decode pop
    rdy = 1'b0; rv_lat = 1;
    do_reset();
    for (int i = 0; i < 60 && !(sb.size() >= 2 && outstanding && resp_cnt == 1); i++) step();
    chk("t5_setup", 32'(inst_valid), 32'h1);
    rdy = 1'b1;
    step(1'b1, 32'h200);
    chk("t5_flushed", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) step();
    chk("t5_target_pc", inst_pc, 32'h200);
    // second branch during SQUASH: the later target wins (low bits ignored)
    rv_lat = 3;
    for (int i = 0; i < 40 && !(outstanding && resp_cnt == 3); i++) step();
    step(1'b1, 32'h300);
    step(1'b1, 32'h407);
    chk("t5_squash_empty", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) step();
    chk("t5_later_target", inst_pc, 32'h404);
    chk("t5_later_inst", inst, data_of(32'h404));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
